// File: rtl/spi_master.sv
// Byte-wide SPI master, mode 0, MSB first, for SD-card access.
// Also drives card power-up clocking and chip select.
module spi_master #(
  parameter int DIV           = 2,
  parameter int TIMEOUT_BYTES = 256
) (
  input  logic       clock,
  input  logic       reset_n,
  output logic       spi_cs,
  output logic       spi_sclk,
  input  logic       spi_miso,
  output logic       spi_mosi,
  input  logic       spi_sent,
  input  logic [1:0] spi_cmd,
  output logic [7:0] spi_din,
  input  logic [7:0] spi_out,
  output logic [1:0] spi_st
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DUMMY,
    DONE
  } state_t;

  localparam logic [1:0] CMD_XFER  = 2'd0;
  localparam logic [1:0] CMD_INIT  = 2'd1;
  localparam logic [1:0] CMD_SEL   = 2'd2;
  localparam logic [1:0] CMD_DESEL = 2'd3;

  localparam logic [7:0]  DIV_M1 = 8'(DIV - 1);
  localparam logic [15:0] TO_MAX = 16'(TIMEOUT_BYTES);
  localparam logic [15:0] TO_M1  = 16'(TIMEOUT_BYTES - 1);

  state_t      state;
  state_t      state_nxt;
  logic        sent_q;
  logic        start;
  logic [7:0]  ctr;
  logic [7:0]  ph;
  logic [7:0]  last_ph;
  logic [7:0]  ctr_nxt;
  logic [7:0]  ph_nxt;
  logic        ph_end;
  logic        at_end;
  logic [7:0]  tx;
  logic [7:0]  rx;
  logic        is_xfer;
  logic        tout;
  logic [15:0] ff_cnt;

  assign start   = spi_sent & ~sent_q;
  assign ph_end  = (ctr == DIV_M1);
  assign ctr_nxt = ph_end ? 8'd0 : ctr + 8'd1;
  assign ph_nxt  = ph_end ? ph + 8'd1 : ph;
  // Leave the clocking state one cycle early: DONE is the final high cycle.
  assign at_end  = (ph_nxt == last_ph) && (ctr_nxt == DIV_M1);
  assign spi_st  = {tout, state != IDLE};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          unique case (spi_cmd)
            CMD_XFER:  state_nxt = SHIFT;
            CMD_INIT:  state_nxt = DUMMY;
            CMD_SEL:   state_nxt = DONE;
            CMD_DESEL: state_nxt = DUMMY;
          endcase
        end
      end
      SHIFT, DUMMY: begin
        if (at_end) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sent_q   <= 1'b0;
      spi_cs   <= 1'b1;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b1;
      spi_din  <= 8'hFF;
      tout     <= 1'b0;
      ff_cnt   <= 16'd0;
      ctr      <= 8'd0;
      ph       <= 8'd0;
      last_ph  <= 8'd15;
      tx       <= 8'hFF;
      rx       <= 8'hFF;
      is_xfer  <= 1'b0;
    end else begin
      sent_q <= spi_sent;
      unique case (state)
        IDLE: begin
          if (start) begin
            ctr     <= 8'd0;
            ph      <= 8'd0;
            is_xfer <= (spi_cmd == CMD_XFER);
            last_ph <= (spi_cmd == CMD_INIT) ? 8'd159 : 8'd15;
            unique case (spi_cmd)
              CMD_XFER: begin
                tx       <= spi_out;
                spi_mosi <= spi_out[7];
              end
              CMD_INIT: begin
                spi_cs <= 1'b1;
                tout   <= 1'b0;
                ff_cnt <= 16'd0;
              end
              CMD_SEL: begin
                spi_cs <= 1'b0;
                tout   <= 1'b0;
                ff_cnt <= 16'd0;
              end
              CMD_DESEL: spi_cs <= 1'b1;
            endcase
          end
        end
        SHIFT, DUMMY: begin
          ctr <= ctr_nxt;
          ph  <= ph_nxt;
          if (ph_end) begin
            spi_sclk <= ~spi_sclk;
            if (state == SHIFT) begin
              if (!spi_sclk) begin
                rx <= {rx[6:0], spi_miso};
              end else begin
                tx       <= {tx[6:0], 1'b1};
                spi_mosi <= tx[6];
              end
            end
          end
        end
        DONE: begin
          spi_sclk <= 1'b0;
          spi_mosi <= 1'b1;
          if (is_xfer) begin
            spi_din <= rx;
            if (rx == 8'hFF) begin
              if (ff_cnt != TO_MAX) ff_cnt <= ff_cnt + 16'd1;
              if (ff_cnt >= TO_M1) tout <= 1'b1;
            end else begin
              ff_cnt <= 16'd0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with a MISO slave model
// and a queue of expected received bytes.
module tb_spi_master;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       spi_cs;
  logic       spi_sclk;
  logic       spi_miso = 1'b1;
  logic       spi_mosi;
  logic       spi_sent = 1'b0;
  logic [1:0] spi_cmd = 2'd0;
  logic [7:0] spi_din;
  logic [7:0] spi_out = 8'h00;
  logic [1:0] spi_st;

  spi_master #(
    .DIV(2),
    .TIMEOUT_BYTES(4)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .spi_cs(spi_cs),
    .spi_sclk(spi_sclk),
    .spi_miso(spi_miso),
    .spi_mosi(spi_mosi),
    .spi_sent(spi_sent),
    .spi_cmd(spi_cmd),
    .spi_din(spi_din),
    .spi_out(spi_out),
    .spi_st(spi_st)
  );

  always #5 clock = ~clock;

  int         n_assert = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] miso_byte = 8'hFF;

  int         pulses = 0;
  int         busy_cnt = 0;
  int         mosi_low = 0;
  int         cs_low = 0;
  int         fall_k = 0;
  logic [7:0] mosi_seen = 8'h00;
  logic       sclk_prev = 1'b0;

  int         d_pulse;
  int         d_busy;
  int         d_mlow;
  int         d_clow;

  // Slave model and activity counters, sampled mid-cycle.
  always @(negedge clock) begin
    if (spi_sclk && !sclk_prev) begin
      pulses++;
      mosi_seen = {mosi_seen[6:0], spi_mosi};
    end
    if (!spi_st[0]) fall_k = 0;
    else if (!spi_sclk && sclk_prev) fall_k++;
    if (spi_st[0]) begin
      busy_cnt++;
      if (!spi_mosi) mosi_low++;
      if (!spi_cs) cs_low++;
    end
    spi_miso = (fall_k < 8) ? miso_byte[3'(7 - fall_k)] : 1'b1;
    sclk_prev = spi_sclk;
  end

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [1:0] c, input logic [7:0] d,
                         input logic [7:0] mb, input int hold,
                         input bit reedge);
    int n;
    int min_n;
    int p0;
    int b0;
    int m0;
    int c0;
    bit ok;
    logic [7:0] e;
    miso_byte = mb;
    @(negedge clock);
    p0 = pulses;
    b0 = busy_cnt;
    m0 = mosi_low;
    c0 = cs_low;
    if (c == 2'd0) exp_q.push_back(mb);
    spi_cmd  = c;
    spi_out  = d;
    spi_sent = 1'b1;
    min_n = (hold < 2) ? 2 : hold;
    if (reedge && min_n < 15) min_n = 15;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 5000) begin
      @(negedge clock);
      n++;
      if (n == hold) spi_sent = 1'b0;
      if (reedge && n == 12) spi_sent = 1'b1;
      if (reedge && n == 14) spi_sent = 1'b0;
      if (n >= min_n && !spi_st[0]) ok = 1'b1;
    end
    spi_sent = 1'b0;
    chk("complete", 16'(ok), 16'd1);
    if (c == 2'd0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("din", 16'(spi_din), 16'(e));
    end
    d_pulse = pulses - p0;
    d_busy  = busy_cnt - b0;
    d_mlow  = mosi_low - m0;
    d_clow  = cs_low - c0;
  endtask

  initial begin
    int n;
    int p0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    chk("rst_cs", 16'(spi_cs), 16'd1);
    chk("rst_sclk", 16'(spi_sclk), 16'd0);
    chk("rst_mosi", 16'(spi_mosi), 16'd1);
    chk("rst_st", 16'(spi_st), 16'd0);
    chk("rst_din", 16'(spi_din), 16'hFF);

    run_cmd(2'd2, 8'h00, 8'hFF, 1, 1'b0);
    chk("sel_cs", 16'(spi_cs), 16'd0);
    chk("sel_busy", 16'(d_busy), 16'd1);

    run_cmd(2'd0, 8'hA5, 8'hFF, 1, 1'b0);
    chk("a5_busy", 16'(d_busy), 16'd32);
    chk("a5_pulses", 16'(d_pulse), 16'd8);
    chk("a5_mosi", 16'(mosi_seen), 16'hA5);
    chk("a5_st", 16'(spi_st), 16'd0);
    chk("a5_sclk", 16'(spi_sclk), 16'd0);
    chk("a5_mosi_idle", 16'(spi_mosi), 16'd1);

    run_cmd(2'd0, 8'h00, 8'hFF, 1, 1'b0);
    run_cmd(2'd0, 8'h00, 8'hFF, 1, 1'b0);
    chk("ff3_tout", 16'(spi_st[1]), 16'd0);

    run_cmd(2'd0, 8'h5A, 8'h3C, 1, 1'b0);
    chk("3c_mosi", 16'(mosi_seen), 16'h5A);
    chk("3c_tout", 16'(spi_st[1]), 16'd0);

    for (int i = 0; i < 3; i++) run_cmd(2'd0, 8'hFF, 8'hFF, 1, 1'b0);
    chk("to3_tout", 16'(spi_st[1]), 16'd0);
    run_cmd(2'd0, 8'hFF, 8'hFF, 1, 1'b0);
    chk("to4_tout", 16'(spi_st[1]), 16'd1);

    run_cmd(2'd1, 8'h00, 8'h00, 1, 1'b0);
    chk("init_cs", 16'(spi_cs), 16'd1);
    chk("init_pulses", 16'(d_pulse), 16'd80);
    chk("init_busy", 16'(d_busy), 16'd320);
    chk("init_mosi_low", 16'(d_mlow), 16'd0);
    chk("init_cs_low", 16'(d_clow), 16'd0);
    chk("init_st", 16'(spi_st), 16'd0);
    chk("init_din", 16'(spi_din), 16'hFF);

    run_cmd(2'd2, 8'h00, 8'hFF, 1, 1'b0);
    for (int i = 0; i < 4; i++) run_cmd(2'd0, 8'h11, 8'hFF, 1, 1'b0);
    chk("to_set", 16'(spi_st), 16'b10);
    run_cmd(2'd2, 8'h00, 8'hFF, 1, 1'b0);
    chk("sel_clr", 16'(spi_st), 16'b00);
    chk("sel_cs2", 16'(spi_cs), 16'd0);

    run_cmd(2'd3, 8'h00, 8'h00, 1, 1'b0);
    chk("desel_cs", 16'(spi_cs), 16'd1);
    chk("desel_pulses", 16'(d_pulse), 16'd8);
    chk("desel_busy", 16'(d_busy), 16'd32);
    chk("desel_mosi_low", 16'(d_mlow), 16'd0);
    chk("desel_din", 16'(spi_din), 16'hFF);

    run_cmd(2'd2, 8'h00, 8'hFF, 1, 1'b0);
    run_cmd(2'd0, 8'h81, 8'hC3, 100, 1'b0);
    chk("hold_pulses", 16'(d_pulse), 16'd8);
    chk("hold_busy", 16'(d_busy), 16'd32);
    chk("hold_mosi", 16'(mosi_seen), 16'h81);
    repeat (5) @(negedge clock);
    chk("hold_idle", 16'(spi_st[0]), 16'd0);

    run_cmd(2'd0, 8'h7E, 8'h42, 1, 1'b1);
    chk("reedge_pulses", 16'(d_pulse), 16'd8);
    chk("reedge_busy", 16'(d_busy), 16'd32);
    repeat (5) @(negedge clock);
    chk("reedge_idle", 16'(spi_st[0]), 16'd0);

    miso_byte = 8'h00;
    @(negedge clock);
    p0 = pulses;
    spi_cmd  = 2'd0;
    spi_out  = 8'h00;
    spi_sent = 1'b1;
    n = 0;
    while (pulses - p0 < 3 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("mid_reached", 16'(pulses - p0 >= 3), 16'd1);
    chk("mid_busy", 16'(spi_st[0]), 16'd1);
    reset_n = 1'b0;
    @(negedge clock);
    chk("mid_rst_cs", 16'(spi_cs), 16'd1);
    chk("mid_rst_sclk", 16'(spi_sclk), 16'd0);
    chk("mid_rst_mosi", 16'(spi_mosi), 16'd1);
    chk("mid_rst_din", 16'(spi_din), 16'hFF);
    chk("mid_rst_st", 16'(spi_st), 16'd0);
    reset_n  = 1'b1;
    spi_sent = 1'b0;
    chk("queue_empty", 16'(exp_q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
